// File: rtl/clk_div_pkg.sv
// Shared constants, config record and legality rule for the clock divider bank.
package clk_div_pkg;

    localparam int CNT_W_DFLT = 28;
    localparam int DIV_DFLT   = 100_000_000;
    localparam int HIGH_DFLT  = 50_000_000;

    // Fields are fixed at 32 bits so any CNT_W up to 32 zero-extends into them.
    typedef struct packed {
        logic [31:0] div;
        logic [31:0] high;
    } chan_cfg_t;

    function automatic logic cfg_legal(input chan_cfg_t cfg);
        return (cfg.div >= 32'd2) && (cfg.high != 32'd0) && (cfg.high < cfg.div);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active and pending config, registered outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DFLT,
    parameter int DEF_DIV  = DIV_DFLT,
    parameter int DEF_HIGH = HIGH_DFLT
) (
    input  logic             CLK100MHZ,
    input  logic             reset_n,
    input  logic             en,
    input  logic             restart,
    input  logic             load_now,
    input  logic             load_pend,
    input  logic [CNT_W-1:0] new_div,
    input  logic [CNT_W-1:0] new_high,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEF_HIGH);

    logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, high_q, high_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d, phigh_q, phigh_d;
    logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
    logic             wrap;

    assign wrap = en && (cnt_q == div_q - ONE);

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        high_d  = high_q;
        pdiv_d  = pdiv_q;
        phigh_d = phigh_q;
        pend_d  = pend_q;
        clk_d   = 1'b0;
        tick_d  = 1'b0;
        if (restart) begin
            cnt_d = '0;
            if (pend_q) begin
                div_d  = pdiv_q;
                high_d = phigh_q;
                pend_d = 1'b0;
            end
        end else if (load_now) begin
            cnt_d  = '0;
            div_d  = new_div;
            high_d = new_high;
        end else if (en) begin
            clk_d  = cnt_q < high_q;
            tick_d = cnt_q == '0;
            cnt_d  = wrap ? '0 : cnt_q + ONE;
            // Deferred config swaps in only once the old period has fully run.
            if (wrap && pend_q) begin
                div_d  = pdiv_q;
                high_d = phigh_q;
                pend_d = 1'b0;
            end
        end else begin
            cnt_d = '0;
            if (pend_q) begin
                div_d  = pdiv_q;
                high_d = phigh_q;
                pend_d = 1'b0;
            end
        end
        // Only reachable while nothing is pending, so it never races an apply.
        if (load_pend) begin
            pend_d  = 1'b1;
            pdiv_d  = new_div;
            phigh_d = new_high;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            div_q   <= RST_DIV;
            high_q  <= RST_HIGH;
            pdiv_q  <= '0;
            phigh_q <= '0;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            high_q  <= high_d;
            pdiv_q  <= pdiv_d;
            phigh_q <= phigh_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign pending = pend_q;
    assign clk_out = clk_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of programmable clock/tick dividers sharing one config port and restart.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = CNT_W_DFLT,
    parameter int DEF_DIV  = DIV_DFLT,
    parameter int DEF_HIGH = HIGH_DFLT,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK100MHZ,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic              cfg_now,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] pending, load_now, load_pend;
    logic              sel_pend, xfer, legal, cfg_err_q, cfg_err_d;
    chan_cfg_t         req;

    always_comb begin
        sel_pend = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) sel_pend = pending[i];
        end
        req       = '{div: 32'(cfg_div), high: 32'(cfg_high)};
        cfg_ready = ~sel_pend & ~sync_restart;
        xfer      = cfg_valid & cfg_ready;
        // Out-of-range channel selects are accepted and reported, never applied.
        legal     = cfg_legal(req) && (32'(cfg_ch) < NUM_CH);
        cfg_err_d = xfer & ~legal;
        for (int i = 0; i < NUM_CH; i++) begin
            load_now[i]  = xfer & legal & cfg_now & (cfg_ch == CH_W'(i));
            load_pend[i] = xfer & legal & ~cfg_now & (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!reset_n) cfg_err_q <= 1'b0;
        else          cfg_err_q <= cfg_err_d;
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV),
            .DEF_HIGH(DEF_HIGH)
        ) u_chan (
            .CLK100MHZ(CLK100MHZ),
            .reset_n  (reset_n),
            .en       (ch_en[g]),
            .restart  (sync_restart),
            .load_now (load_now[g]),
            .load_pend(load_pend[g]),
            .new_div  (cfg_div),
            .new_high (cfg_high),
            .pending  (pending[g]),
            .clk_out  (clk_out[g]),
            .tick     (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scenario bench for clk_div_bank against a per-channel phase/period reference model.
module tb_clk_div_bank;

    logic        clk = 1'b0;
    logic        reset_n, sync_restart, cfg_valid, cfg_now, cfg_ch;
    logic [1:0]  ch_en;
    logic [27:0] cfg_div, cfg_high;
    logic        cfg_ready, cfg_err;
    logic [1:0]  clk_out, tick;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clk_div_bank #(.NUM_CH(2), .CNT_W(28), .DEF_DIV(10), .DEF_HIGH(5)) dut (
        .CLK100MHZ(clk), .reset_n(reset_n), .ch_en(ch_en), .sync_restart(sync_restart),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_high(cfg_high), .cfg_now(cfg_now), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick)
    );

    // Reference model: phase within the period, active/pending period and high time.
    int         m_ph[2], m_div[2], m_high[2], m_pdiv[2], m_phigh[2];
    bit         m_pend[2];
    logic [1:0] m_clk = '0, m_tick = '0;
    logic       m_err = 1'b0;
    int         m_xfers = 0;
    logic       m_ready;

    assign m_ready = !m_pend[cfg_ch] && !sync_restart;

    always @(posedge clk) begin : p_model
        bit xfer, legal, mine;
        xfer  = cfg_valid && m_ready;
        legal = (cfg_div >= 2) && (cfg_high != 0) && (cfg_high < cfg_div);
        if (!reset_n) begin
            for (int c = 0; c < 2; c++) begin
                m_ph[c] = 0; m_div[c] = 10; m_high[c] = 5; m_pend[c] = 0;
            end
            m_clk = '0; m_tick = '0; m_err = 1'b0;
        end else begin
            m_err = xfer && !legal;
            if (xfer) m_xfers++;
            for (int c = 0; c < 2; c++) begin
                mine = xfer && legal && (cfg_ch == c);
                m_clk[c] = 1'b0; m_tick[c] = 1'b0;
                if (sync_restart || (mine && cfg_now) || !ch_en[c]) begin
                    m_ph[c] = 0;
                    if (!sync_restart && mine && cfg_now) begin
                        m_div[c] = int'(cfg_div); m_high[c] = int'(cfg_high);
                    end else if (m_pend[c]) begin
                        m_div[c] = m_pdiv[c]; m_high[c] = m_phigh[c]; m_pend[c] = 0;
                    end
                end else begin
                    m_clk[c]  = m_ph[c] < m_high[c];
                    m_tick[c] = m_ph[c] == 0;
                    m_ph[c]   = (m_ph[c] + 1) % m_div[c];
                    if (m_ph[c] == 0 && m_pend[c]) begin
                        m_div[c] = m_pdiv[c]; m_high[c] = m_phigh[c]; m_pend[c] = 0;
                    end
                end
                if (mine && !cfg_now) begin
                    m_pend[c] = 1; m_pdiv[c] = int'(cfg_div); m_phigh[c] = int'(cfg_high);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, cfg_err, cfg_ready} !== 6'b0000_01) begin
                n_bad++;
                $display("FAIL reset_state: clk=%b tick=%b err=%b rdy=%b, want 00 00 0 1", clk_out, tick, cfg_err, cfg_ready);
            end
        end
    endtask

    task automatic test_default_run();
        int nt0 = 0, nt1 = 0, nh0 = 0, nh1 = 0;
        reset_n = 1'b1; ch_en = 2'b11;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, cfg_err, cfg_ready} !== {m_clk, m_tick, m_err, m_ready}) begin
                n_bad++;
                $display("FAIL default_lockstep k=%0d: dut %b%b%b%b model %b%b%b%b", k, clk_out, tick, cfg_err, cfg_ready, m_clk, m_tick, m_err, m_ready);
            end
            if (k == 0) begin
                n_cmp++;
                if ({clk_out, tick} !== 4'b1111) begin
                    n_bad++;
                    $display("FAIL enable_latency: clk=%b tick=%b, want 11 11", clk_out, tick);
                end
            end
            n_cmp++;
            if (tick[0] !== tick[1] || clk_out[0] !== clk_out[1]) begin
                n_bad++;
                $display("FAIL in_phase k=%0d: clk=%b tick=%b", k, clk_out, tick);
            end
            if (tick[0]) nt0++;
            if (tick[1]) nt1++;
            if (clk_out[0]) nh0++;
            if (clk_out[1]) nh1++;
        end
        n_cmp++;
        if (nt0 != 3 || nt1 != 3 || nh0 != 15 || nh1 != 15) begin
            n_bad++;
            $display("FAIL default_counts: ticks %0d/%0d high %0d/%0d, want 3/3 15/15", nt0, nt1, nh0, nh1);
        end
    endtask

    // Both channels sit at cnt=0 on entry; three edges bring ch1 to cnt=3.
    task automatic test_deferred();
        logic et, ec, er;
        repeat (3) @(negedge clk);
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 28'd4; cfg_high = 28'd1; cfg_now = 1'b0;
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL deferred_ready_idle: rdy=%b, want 1", cfg_ready);
        end
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            et = (k >= 7) && ((k - 7) % 4 == 0);
            ec = (k <= 1) || et;
            er = (k >= 6);
            n_cmp++;
            if (tick[1] !== et || clk_out[1] !== ec || cfg_ready !== er) begin
                n_bad++;
                $display("FAIL deferred_apply k=%0d: tick=%b clk=%b rdy=%b, want %b %b %b", k, tick[1], clk_out[1], cfg_ready, et, ec, er);
            end
            n_cmp++;
            if ({clk_out, tick, cfg_err} !== {m_clk, m_tick, m_err}) begin
                n_bad++;
                $display("FAIL deferred_lockstep k=%0d: dut %b%b%b model %b%b%b", k, clk_out, tick, cfg_err, m_clk, m_tick, m_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  base, waited;
        bit  saw_low = 0, got = 0;
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 28'd5; cfg_high = 28'd2; cfg_now = 1'b0;
        base = m_xfers;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, cfg_err, cfg_ready} !== {m_clk, m_tick, m_err, m_ready}) begin
                n_bad++;
                $display("FAIL b2b_lockstep k=%0d: dut %b%b%b%b model %b%b%b%b", k, clk_out, tick, cfg_err, cfg_ready, m_clk, m_tick, m_err, m_ready);
            end
            if (m_xfers == base + 1) begin
                cfg_div = 28'd7; cfg_high = 28'd3;
            end else if (m_xfers == base + 2) begin
                got = 1; waited = k; cfg_valid = 1'b0;
            end
            if (m_xfers == base + 1 && cfg_ready === 1'b0) saw_low = 1;
        end
        n_cmp++;
        if (!got || !saw_low) begin
            n_bad++;
            $display("FAIL b2b_holdoff: second accepted=%0d held_low=%0d, want 1 1", got, saw_low);
        end
        repeat (24) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, cfg_err, cfg_ready} !== {m_clk, m_tick, m_err, m_ready}) begin
                n_bad++;
                $display("FAIL b2b_tail: dut %b%b%b%b model %b%b%b%b", clk_out, tick, cfg_err, cfg_ready, m_clk, m_tick, m_err, m_ready);
            end
        end
    endtask

    task automatic test_immediate();
        logic et, ec;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 28'd6; cfg_high = 28'd3; cfg_now = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            et = (k >= 1) && ((k - 1) % 6 == 0);
            ec = (k >= 1) && ((k - 1) % 6 < 3);
            n_cmp++;
            if (tick[0] !== et || clk_out[0] !== ec) begin
                n_bad++;
                $display("FAIL immediate k=%0d: tick=%b clk=%b, want %b %b", k, tick[0], clk_out[0], et, ec);
            end
        end
    endtask

    task automatic test_illegal();
        logic [27:0] dv[3] = '{28'd1, 28'd6, 28'd8};
        logic [27:0] hv[3] = '{28'd1, 28'd0, 28'd8};
        int pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = dv[i]; cfg_high = hv[i]; cfg_now = 1'b1;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                cfg_valid = 1'b0;
                if (cfg_err === 1'b1) pulses++;
                n_cmp++;
                if (cfg_err !== (k == 0)) begin
                    n_bad++;
                    $display("FAIL illegal_err cfg=%0d k=%0d: err=%b, want %b", i, k, cfg_err, k == 0);
                end
                n_cmp++;
                if ({clk_out, tick} !== {m_clk, m_tick}) begin
                    n_bad++;
                    $display("FAIL illegal_period cfg=%0d: clk=%b tick=%b model %b %b", i, clk_out, tick, m_clk, m_tick);
                end
            end
        end
        n_cmp++;
        if (pulses != 3) begin
            n_bad++;
            $display("FAIL illegal_pulses: %0d, want 3", pulses);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 20 && m_pend[1]; k++) @(negedge clk);
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 28'd3; cfg_high = 28'd1; cfg_now = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, cfg_err} !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_mid_outputs: clk=%b tick=%b err=%b, want 0", clk_out, tick, cfg_err);
            end
        end
        reset_n = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if (tick !== {2{k % 10 == 0}} || clk_out !== {2{k % 10 < 5}}) begin
                n_bad++;
                $display("FAIL reset_mid_period k=%0d: tick=%b clk=%b", k, tick, clk_out);
            end
        end
    endtask

    task automatic test_sync_restart();
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 28'd4; cfg_high = 28'd2; cfg_now = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b0; sync_restart = 1'b1;
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_ready: rdy=%b, want 0", cfg_ready);
        end
        @(negedge clk);
        sync_restart = 1'b0;
        n_cmp++;
        if ({clk_out, tick} !== 4'b0) begin
            n_bad++;
            $display("FAIL restart_clear: clk=%b tick=%b, want 00 00", clk_out, tick);
        end
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (tick !== {k % 10 == 0, k % 4 == 0}) begin
                n_bad++;
                $display("FAIL restart_ticks k=%0d: tick=%b, want %b", k, tick, {k % 10 == 0, k % 4 == 0});
            end
        end
    endtask

    task automatic test_random();
        int  xb = m_xfers;
        bit  held;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, cfg_err, cfg_ready} !== {m_clk, m_tick, m_err, m_ready}) begin
                n_bad++;
                $display("FAIL random_lockstep k=%0d: dut %b%b%b%b model %b%b%b%b", k, clk_out, tick, cfg_err, cfg_ready, m_clk, m_tick, m_err, m_ready);
            end
            held = cfg_valid && (m_xfers == xb);
            xb   = m_xfers;
            ch_en        = {($urandom_range(7) != 0), ($urandom_range(7) != 0)};
            sync_restart = ($urandom_range(31) == 0);
            cfg_valid    = ($urandom_range(2) == 0);
            if (!held) cfg_ch = 1'($urandom_range(1));
            cfg_div  = 28'($urandom_range(12));
            cfg_high = 28'($urandom_range(12));
            cfg_now  = 1'($urandom_range(1));
        end
        cfg_valid = 1'b0; sync_restart = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; ch_en = 2'b00; sync_restart = 1'b0; cfg_valid = 1'b0;
        cfg_ch = 1'b0; cfg_div = '0; cfg_high = '0; cfg_now = 1'b0;
        test_reset();
        test_default_run();
        test_deferred();
        test_back_to_back();
        test_immediate();
        test_illegal();
        test_reset_mid();
        test_sync_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
